// File: rtl/instruction_fetch_unit.sv
// Fetch stage: word reads from instruction memory over req/ack into a small {pc, instr} FIFO.
// Optional IFU_MISALIGN_TRAP_EN: a misaligned redirect raises a sticky fault and stalls fetch.
module instruction_fetch_unit #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  pc_load,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic                  misalign_fault
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];

  logic                  pop_c;
  logic                  push_c;
  logic                  room_c;
  logic                  trap_hold_c;
  logic [CNT_W-1:0]      count_n_c;
  logic [PTR_W-1:0]      rd_ptr_n_c;
  logic [DATA_WIDTH-1:0] head_data_c;
  logic [ADDR_WIDTH-1:0] head_pc_c;

  assign imem_addr = fetch_pc;

  // FIFO bookkeeping for this cycle; the head register is reloaded from the post-pop slot
  always_comb begin
    pop_c      = instr_valid & instr_ready;
    push_c     = (state == REQ) & imem_ack & ~pc_load;
    count_n_c  = count + CNT_W'(push_c) - CNT_W'(pop_c);
    rd_ptr_n_c = rd_ptr + PTR_W'(pop_c);
    room_c     = count_n_c < CNT_W'(FIFO_DEPTH);
    head_data_c = mem_data[rd_ptr_n_c];
    head_pc_c   = mem_pc[rd_ptr_n_c];
    // Only an empty-after-pop FIFO can have the write slot as its new head
    if (push_c && (wr_ptr == rd_ptr_n_c)) begin
      head_data_c = imem_rdata;
      head_pc_c   = fetch_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (push_c) begin
      mem_data[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else if (pc_load) begin
      // An unanswered request must still be drained before fetching resumes
      state       <= ((state == IDLE) || imem_ack) ? IDLE : DROP;
      imem_req    <= 1'b0;
      fetch_pc    <= pc_in & ~ADDR_WIDTH'(3);
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
    end else begin
      rd_ptr      <= rd_ptr_n_c;
      count       <= count_n_c;
      instr_valid <= (count_n_c != '0);
      if (count_n_c != '0) begin
        instr    <= head_data_c;
        instr_pc <= head_pc_c;
      end
      if (push_c) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
      case (state)
        IDLE: begin
          if (room_c && !trap_hold_c) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack && !room_c) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  // Sticky until the next redirect with an aligned target
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      misalign_fault <= 1'b0;
    end else if (pc_load) begin
      misalign_fault <= |pc_in[1:0];
    end
  end
  assign trap_hold_c = misalign_fault;
`else
  assign misalign_fault = 1'b0;
  assign trap_hold_c    = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a variable-latency memory responder.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_load;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign_fault;

  int          vectors;
  int          errors;
  int unsigned lat;
  logic        pending;
  int unsigned cnt;
  logic [31:0] req_addr;
  logic [31:0] ack_log [$];
  logic [31:0] got_pc [$];
  logic [31:0] got_data [$];
  int          ab;
  int          gb;
  logic        saw_req;

  instruction_fetch_unit dut (
    .clock          (clk),
    .reset          (rst_n),
    .pc_in          (pc_in),
    .pc_load        (pc_load),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: captures the address when a request appears, acks `lat` cycles later even if req drops
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    pending    = 1'b0;
    cnt        = 0;
    req_addr   = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_ack = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
        cnt     = 0;
      end else begin
        if (!pending && imem_req) begin
          pending  = 1'b1;
          cnt      = 0;
          req_addr = imem_addr;
        end
        if (pending) begin
          cnt = cnt + 1;
          if (cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = req_addr + 32'h1000_0000;
            ack_log.push_back(req_addr);
            pending    = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    pc_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_got(input int base, input int n, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (got_pc.size() >= base + n) break;
      @(posedge clk);
      #1;
    end
    check(tag, 32'(got_pc.size() >= base + n), 32'd1);
  endtask

  initial begin
    vectors     = 0;
    errors      = 0;
    rst_n       = 1'b0;
    pc_load     = 1'b0;
    pc_in       = '0;
    instr_ready = 1'b0;
    lat         = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, 32'h0000_0000);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc",    instr_pc, 32'h0);
    check("rst_fault", 32'(misalign_fault), 32'd0);

    // Stalled decode: FIFO fills with PC 0 and 4, then fetch stops
    ab = ack_log.size();
    gb = got_pc.size();
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("full_acks",  32'(ack_log.size() - ab), 32'd2);
    check("full_addr0", ack_log[ab], 32'h0000_0000);
    check("full_addr1", ack_log[ab+1], 32'h0000_0004);
    check("full_req",   32'(imem_req), 32'd0);
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_hpc",   instr_pc, 32'h0000_0000);
    check("full_hdata", instr, 32'h1000_0000);
    instr_ready = 1'b1;
    wait_got(gb, 3, "seq_count");
    check("seq_pc0",   got_pc[gb],     32'h0000_0000);
    check("seq_d0",    got_data[gb],   32'h1000_0000);
    check("seq_pc1",   got_pc[gb+1],   32'h0000_0004);
    check("seq_d1",    got_data[gb+1], 32'h1000_0004);
    check("seq_pc2",   got_pc[gb+2],   32'h0000_0008);
    check("seq_d2",    got_data[gb+2], 32'h1000_0008);
    check("seq_addr2", ack_log[ab+2],  32'h0000_0008);

    // Redirect while a slow request is outstanding
    lat = 3;
    apply_reset();
    ab = ack_log.size();
    gb = got_pc.size();
    @(posedge clk);
    #1;
    check("drop_req_up", 32'(imem_req), 32'd1);
    pc_load = 1'b1;
    pc_in   = 32'h0000_2800;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    check("drop_req",   32'(imem_req), 32'd0);
    check("drop_valid", 32'(instr_valid), 32'd0);
    check("drop_addr",  imem_addr, 32'h0000_2800);
    wait_got(gb, 1, "drop_count");
    check("drop_pc",    got_pc[gb],   32'h0000_2800);
    check("drop_data",  got_data[gb], 32'h1000_2800);
    check("drop_stale", ack_log[ab],  32'h0000_0000);
    check("drop_next",  ack_log[ab+1], 32'h0000_2800);

    // Redirect in the same cycle as the ack
    lat = 2;
    apply_reset();
    gb = got_pc.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_ack) break;
    end
    check("same_ack_seen", 32'(imem_ack), 32'd1);
    pc_load = 1'b1;
    pc_in   = 32'h0000_0100;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    check("same_valid", 32'(instr_valid), 32'd0);
    wait_got(gb, 1, "same_count");
    check("same_pc",   got_pc[gb],   32'h0000_0100);
    check("same_data", got_data[gb], 32'h1000_0100);

    // Address wrap at the top of the space
    lat = 1;
    apply_reset();
    gb      = got_pc.size();
    pc_load = 1'b1;
    pc_in   = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    wait_got(gb, 2, "wrap_count");
    check("wrap_pc0", got_pc[gb],     32'hFFFF_FFFC);
    check("wrap_d0",  got_data[gb],   32'h0FFF_FFFC);
    check("wrap_pc1", got_pc[gb+1],   32'h0000_0000);
    check("wrap_d1",  got_data[gb+1], 32'h1000_0000);

    // Misaligned redirect target
    apply_reset();
    gb      = got_pc.size();
    pc_load = 1'b1;
    pc_in   = 32'h0000_0102;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    check("mis_fault", 32'(misalign_fault), 32'd1);
    saw_req = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (imem_req) saw_req = 1'b1;
    end
    check("mis_blocked", 32'(saw_req), 32'd0);
    pc_load = 1'b1;
    pc_in   = 32'h0000_0200;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    check("mis_clear", 32'(misalign_fault), 32'd0);
    wait_got(gb, 1, "mis_count");
    check("mis_pc",   got_pc[gb],   32'h0000_0200);
    check("mis_data", got_data[gb], 32'h1000_0200);
`else
    saw_req = 1'b0;
    check("mis_fault", 32'(misalign_fault), 32'd0);
    wait_got(gb, 1, "mis_count");
    check("mis_pc",   got_pc[gb],   32'h0000_0100);
    check("mis_data", got_data[gb], 32'h1000_0100);
`endif

    // Reset asserted while a request is outstanding
    lat = 3;
    apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req",   32'(imem_req), 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_addr",  imem_addr, 32'h0000_0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
